axi_rr_ptr_gen: RTL and testbench

- Parametrised round-robin priority-pointer generator for the AXI node arbiters.
- Successor to the fixed-increment RR flag counter. Adds:
  - a runtime-programmable wrap limit;
  - a true round-robin mode, where the pointer follows the last winner;
  - burst lock, which freezes the pointer until the last beat;
  - a synchronous clear;
  - one-hot and wrap outputs.
- Sits beside each request-tree arbiter and drives its priority input.

---
 rtl/axi_rr_pkg.sv | 14 +
 rtl/axi_rr_next_ptr.sv | 31 +++
 rtl/axi_rr_ptr_gen.sv | 96 +++++++++
 tb/tb_axi_rr_ptr_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rr_pkg.sv
// rtl/axi_rr_pkg.sv - shared types and constants for the round-robin pointer generator
package axi_rr_pkg;

  // Burst-lock state of the pointer generator
  typedef enum logic {
    S_FREE   = 1'b0,
    S_LOCKED = 1'b1
  } rr_state_e;

  // Pointer advance policy selected by mode_i
  localparam logic RR_MODE_INC    = 1'b0;
  localparam logic RR_MODE_WINNER = 1'b1;

endpackage

// File: rtl/axi_rr_next_ptr.sv
// rtl/axi_rr_next_ptr.sv - wrap-limit clamp and next-pointer computation
import axi_rr_pkg::*;

module axi_rr_next_ptr #(
  parameter int N_REQ = 8,
  parameter int WIDTH = $clog2(N_REQ)
) (
  input  logic             mode_i,
  input  logic [WIDTH:0]   max_count_i,
  input  logic [WIDTH-1:0] cur_ptr_i,
  input  logic [WIDTH-1:0] winner_idx_i,
  output logic [WIDTH-1:0] nxt_o
);

  localparam logic [WIDTH:0] N_REQ_W = (WIDTH+1)'(N_REQ);

  logic [WIDTH:0]   w_lim;
  logic [WIDTH:0]   w_lim_m1;
  logic [WIDTH-1:0] w_base;

  // A zero or oversized limit falls back to the full requestor count
  assign w_lim    = ((max_count_i == '0) || (max_count_i > N_REQ_W)) ? N_REQ_W : max_count_i;
  assign w_lim_m1 = w_lim - 1'b1;

  // Increment mode steps from the current pointer, winner mode from the granted index
  assign w_base = (mode_i == RR_MODE_WINNER) ? winner_idx_i : cur_ptr_i;

  // ">=" rather than "==" so a pointer left out of range by a shrinking limit returns to 0
  assign nxt_o = ({1'b0, w_base} >= w_lim_m1) ? '0 : w_base + 1'b1;

endmodule

// File: rtl/axi_rr_ptr_gen.sv
// rtl/axi_rr_ptr_gen.sv - round-robin priority pointer with burst lock and wrap pulse
import axi_rr_pkg::*;

module axi_rr_ptr_gen #(
  parameter int N_REQ   = 8,
  parameter int WIDTH   = $clog2(N_REQ),
  parameter int LOCK_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             mode_i,
  input  logic [WIDTH:0]   max_count_i,
  input  logic             data_req_i,
  input  logic             data_gnt_i,
  input  logic [WIDTH-1:0] winner_idx_i,
  input  logic             lock_i,
  input  logic             last_i,
  output logic [WIDTH-1:0] rr_flag_o,
  output logic [N_REQ-1:0] rr_flag_onehot_o,
  output logic             locked_o,
  output logic             wrap_o
);

  localparam logic LOCK_ON = (LOCK_EN != 0);

  rr_state_e        r_state;
  rr_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_flag;
  logic             r_wrap;
  logic [WIDTH-1:0] w_nxt_ptr;
  logic             w_hs;
  logic             w_adv;

  assign w_hs = data_req_i & data_gnt_i;

  axi_rr_next_ptr #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH)
  ) u_next_ptr (
    .mode_i       (mode_i),
    .max_count_i  (max_count_i),
    .cur_ptr_i    (r_flag),
    .winner_idx_i (winner_idx_i),
    .nxt_o        (w_nxt_ptr)
  );

  // Next-state and advance decision; pointer stays frozen for the whole of a burst
  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    case (r_state)
      S_FREE: begin
        if (w_hs) begin
          if (LOCK_ON && lock_i && !last_i) begin
            w_state_nxt = S_LOCKED;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      S_LOCKED: begin
        if (w_hs && last_i) begin
          w_adv       = 1'b1;
          w_state_nxt = S_FREE;
        end
      end
      default: w_state_nxt = S_FREE;
    endcase
  end

  // State, pointer and wrap pulse registers; clear wins over a coincident handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FREE;
      r_flag  <= '0;
      r_wrap  <= 1'b0;
    end else if (clear_i) begin
      r_state <= S_FREE;
      r_flag  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wrap  <= w_adv && (w_nxt_ptr == '0) && (r_flag != '0);
      if (w_adv) begin
        r_flag <= w_nxt_ptr;
      end
    end
  end

  assign rr_flag_o        = r_flag;
  assign rr_flag_onehot_o = N_REQ'(1) << r_flag;
  assign locked_o         = (r_state == S_LOCKED);
  assign wrap_o           = r_wrap;

endmodule

// File: tb/tb_axi_rr_ptr_gen.sv
// tb/tb_axi_rr_ptr_gen.sv - scoreboard bench for the round-robin pointer generator
module tb_axi_rr_ptr_gen;

  typedef struct packed {
    logic [2:0] ptr;
    logic       locked;
    logic       wrap;
  } exp_t;

  localparam logic [7:0] ONE = 8'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_i;
  logic       mode_i;
  logic [3:0] max_count_i;
  logic       data_req_i;
  logic       data_gnt_i;
  logic [2:0] winner_idx_i;
  logic       lock_i;
  logic       last_i;

  logic [2:0] rr_flag;
  logic [7:0] rr_onehot;
  logic       locked;
  logic       wrap;
  logic [2:0] rr_flag2;
  logic [7:0] rr_onehot2;
  logic       locked2;
  logic       wrap2;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_rr_ptr_gen #(.N_REQ(8), .LOCK_EN(1)) dut (
    .clk (clk), .rst (rst), .clear_i (clear_i), .mode_i (mode_i),
    .max_count_i (max_count_i), .data_req_i (data_req_i), .data_gnt_i (data_gnt_i),
    .winner_idx_i (winner_idx_i), .lock_i (lock_i), .last_i (last_i),
    .rr_flag_o (rr_flag), .rr_flag_onehot_o (rr_onehot), .locked_o (locked), .wrap_o (wrap)
  );

  axi_rr_ptr_gen #(.N_REQ(8), .LOCK_EN(0)) dut_nolock (
    .clk (clk), .rst (rst), .clear_i (clear_i), .mode_i (mode_i),
    .max_count_i (max_count_i), .data_req_i (data_req_i), .data_gnt_i (data_gnt_i),
    .winner_idx_i (winner_idx_i), .lock_i (lock_i), .last_i (last_i),
    .rr_flag_o (rr_flag2), .rr_flag_onehot_o (rr_onehot2), .locked_o (locked2), .wrap_o (wrap2)
  );

  task automatic idle_inputs();
    clear_i = 0; data_req_i = 0; data_gnt_i = 0; lock_i = 0; last_i = 0; winner_idx_i = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    mode_i = 0;
    max_count_i = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic apply(input logic req, input logic gnt, input logic lck, input logic lst,
                       input logic clr, input logic [2:0] win);
    @(negedge clk);
    data_req_i = req; data_gnt_i = gnt; lock_i = lck; last_i = lst; clear_i = clr; winner_idx_i = win;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    mode_i = 0;
    max_count_i = 0;
    #12;
    checks++;
    if ({rr_flag, rr_onehot, locked, wrap} !== {3'd0, 8'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: ptr=%0d onehot=%b locked=%b wrap=%b, expected ptr=0 onehot=00000001 locked=0 wrap=0",
               rr_flag, rr_onehot, locked, wrap);
    end
    checks++;
    if ({rr_flag2, rr_onehot2, locked2, wrap2} !== {3'd0, 8'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_nolock: ptr=%0d onehot=%b locked=%b wrap=%b, expected ptr=0 onehot=00000001",
               rr_flag2, rr_onehot2, locked2, wrap2);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_inc_wrap();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{ptr: 3'((i + 1) % 8), locked: 1'b0, wrap: (i == 7)});
      apply(1, 1, 0, 0, 0, 3'd0);
      e = sb.pop_front();
      checks++;
      if ({rr_flag, rr_onehot, locked, wrap} !== {e.ptr, ONE << e.ptr, e.locked, e.wrap}) begin
        errors++;
        $display("FAIL inc_wrap step %0d: ptr=%0d onehot=%b locked=%b wrap=%b, expected ptr=%0d locked=%b wrap=%b",
                 i, rr_flag, rr_onehot, locked, wrap, e.ptr, e.locked, e.wrap);
      end
    end
    // grant without request, then request without grant: pointer holds, no wrap
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{ptr: 3'd1, locked: 1'b0, wrap: 1'b0});
      apply(i[0], ~i[0], 0, 0, 0, 3'd0);
      e = sb.pop_front();
      checks++;
      if ({rr_flag, rr_onehot, locked, wrap} !== {e.ptr, ONE << e.ptr, e.locked, e.wrap}) begin
        errors++;
        $display("FAIL no_hs_hold step %0d: ptr=%0d wrap=%b, expected ptr=%0d wrap=%b",
                 i, rr_flag, wrap, e.ptr, e.wrap);
      end
    end
  endtask

  task automatic test_limit_clamp();
    logic [2:0] exp_a [4];
    logic [2:0] exp_b [9];
    exp_a = '{3'd1, 3'd2, 3'd0, 3'd1};
    exp_b = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    apply_reset();
    max_count_i = 4'd3;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{ptr: exp_a[i], locked: 1'b0, wrap: (exp_a[i] == 3'd0)});
      apply(1, 1, 0, 0, 0, 3'd0);
      e = sb.pop_front();
      checks++;
      if ({rr_flag, rr_onehot, locked, wrap} !== {e.ptr, ONE << e.ptr, e.locked, e.wrap}) begin
        errors++;
        $display("FAIL limit3 step %0d: ptr=%0d wrap=%b, expected ptr=%0d wrap=%b",
                 i, rr_flag, wrap, e.ptr, e.wrap);
      end
    end
    max_count_i = 4'd12;
    for (int i = 0; i < 9; i++) begin
      sb.push_back('{ptr: exp_b[i], locked: 1'b0, wrap: (exp_b[i] == 3'd0)});
      apply(1, 1, 0, 0, 0, 3'd0);
      e = sb.pop_front();
      checks++;
      if ({rr_flag, rr_onehot, locked, wrap} !== {e.ptr, ONE << e.ptr, e.locked, e.wrap}) begin
        errors++;
        $display("FAIL limit12 step %0d: ptr=%0d wrap=%b, expected ptr=%0d wrap=%b",
                 i, rr_flag, wrap, e.ptr, e.wrap);
      end
    end
  endtask

  task automatic test_follow_winner();
    logic [2:0] win [3];
    logic [2:0] exp_p [3];
    win   = '{3'd5, 3'd7, 3'd2};
    exp_p = '{3'd6, 3'd0, 3'd3};
    apply_reset();
    mode_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{ptr: exp_p[i], locked: 1'b0, wrap: (i == 1)});
      apply(1, 1, 0, 0, 0, win[i]);
      e = sb.pop_front();
      checks++;
      if ({rr_flag, rr_onehot, locked, wrap} !== {e.ptr, ONE << e.ptr, e.locked, e.wrap}) begin
        errors++;
        $display("FAIL follow_winner step %0d: ptr=%0d wrap=%b, expected ptr=%0d wrap=%b",
                 i, rr_flag, wrap, e.ptr, e.wrap);
      end
    end
  endtask

  task automatic test_burst_lock();
    // steps: two single beats, burst start, three middle beats, last beat
    logic lck [7];
    logic lst [7];
    logic [2:0] exp_p [7];
    logic       exp_l [7];
    logic [2:0] exp_p2 [7];
    lck    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    lst    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_p  = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    exp_l  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_p2 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{ptr: exp_p[i], locked: exp_l[i], wrap: 1'b0});
      apply(1, 1, lck[i], lst[i], 0, 3'd0);
      e = sb.pop_front();
      checks++;
      if ({rr_flag, rr_onehot, locked, wrap} !== {e.ptr, ONE << e.ptr, e.locked, e.wrap}) begin
        errors++;
        $display("FAIL burst_lock step %0d: ptr=%0d locked=%b wrap=%b, expected ptr=%0d locked=%b wrap=%b",
                 i, rr_flag, locked, wrap, e.ptr, e.locked, e.wrap);
      end
    end
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{ptr: exp_p2[i], locked: 1'b0, wrap: 1'b0});
      apply(1, 1, lck[i], lst[i], 0, 3'd0);
      e = sb.pop_front();
      checks++;
      if ({rr_flag2, rr_onehot2, locked2, wrap2} !== {e.ptr, ONE << e.ptr, e.locked, e.wrap}) begin
        errors++;
        $display("FAIL nolock step %0d: ptr=%0d locked=%b wrap=%b, expected ptr=%0d locked=%b wrap=%b",
                 i, rr_flag2, locked2, wrap2, e.ptr, e.locked, e.wrap);
      end
    end
  endtask

  task automatic test_clear();
    apply_reset();
    for (int i = 0; i < 6; i++) apply(1, 1, 0, 0, 0, 3'd0);
    sb.push_back('{ptr: 3'd6, locked: 1'b1, wrap: 1'b0});
    apply(1, 1, 1, 0, 0, 3'd0);
    e = sb.pop_front();
    checks++;
    if ({rr_flag, locked} !== {e.ptr, e.locked}) begin
      errors++;
      $display("FAIL clear_setup: ptr=%0d locked=%b, expected ptr=%0d locked=%b", rr_flag, locked, e.ptr, e.locked);
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{ptr: 3'd0, locked: 1'b0, wrap: 1'b0});
      if (i == 0) apply(1, 1, 1, 1, 1, 3'd0);
      else        apply(0, 0, 0, 0, 0, 3'd0);
      e = sb.pop_front();
      checks++;
      if ({rr_flag, rr_onehot, locked, wrap} !== {e.ptr, ONE << e.ptr, e.locked, e.wrap}) begin
        errors++;
        $display("FAIL clear step %0d: ptr=%0d locked=%b wrap=%b, expected ptr=%0d locked=%b wrap=%b",
                 i, rr_flag, locked, wrap, e.ptr, e.locked, e.wrap);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 4; i++) apply(1, 1, 0, 0, 0, 3'd0);
    apply(1, 1, 1, 0, 0, 3'd0);
    checks++;
    if ({rr_flag, locked} !== {3'd4, 1'b1}) begin
      errors++;
      $display("FAIL async_setup: ptr=%0d locked=%b, expected ptr=4 locked=1", rr_flag, locked);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({rr_flag, rr_onehot, locked, wrap} !== {3'd0, 8'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: ptr=%0d onehot=%b locked=%b wrap=%b, expected ptr=0 onehot=00000001 locked=0 wrap=0",
               rr_flag, rr_onehot, locked, wrap);
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();
    sb.push_back('{ptr: 3'd1, locked: 1'b0, wrap: 1'b0});
    apply(1, 1, 0, 0, 0, 3'd0);
    e = sb.pop_front();
    checks++;
    if ({rr_flag, rr_onehot, locked, wrap} !== {e.ptr, ONE << e.ptr, e.locked, e.wrap}) begin
      errors++;
      $display("FAIL after_async: ptr=%0d locked=%b wrap=%b, expected ptr=%0d locked=%b wrap=%b",
               rr_flag, locked, wrap, e.ptr, e.locked, e.wrap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_inc_wrap();
    test_limit_clamp();
    test_follow_winner();
    test_burst_lock();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
